// File: rtl/operand_fetch_if.sv
// operand_fetch_if: instruction-field handshake into the operand-fetch stage
// and operand-pair handshake out of it toward the ALU.
// master = upstream/downstream environment, slave = the operand-fetch stage.
interface operand_fetch_if;
   // upstream instruction fields
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  rs_a;
   logic [3:0]  rs_b;
   logic [3:0]  rd;
   logic [3:0]  op;
   // downstream operand pair
   logic        out_valid;
   logic        out_ready;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic [3:0]  out_rd;
   logic [3:0]  out_op;

   modport master (
      output in_valid, rs_a, rs_b, rd, op, out_ready,
      input  in_ready, out_valid, op_a, op_b, out_rd, out_op
   );

   modport slave (
      input  in_valid, rs_a, rs_b, rd, op, out_ready,
      output in_ready, out_valid, op_a, op_b, out_rd, out_op
   );
endinterface

// File: rtl/operand_fetch.sv
// operand_fetch: reads two source operands from the 16 x 32-bit register bank
// at push time and holds {op_a, op_b, rd, op} in a 2-entry circular buffer
// that sustains one transfer per cycle under back-pressure. Counts cycles in
// which a valid operand pair waits on the ALU (saturating).
// Optional feature: define OPFETCH_BYPASS_EN to forward an in-flight
// write-back value (wb_valid_i/wb_sel_i/wb_data_i) into op_a and/or op_b.
module operand_fetch #(
   parameter int DEPTH   = 2,   // fixed buffer depth; pointers are 1 bit
   parameter int STALL_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   operand_fetch_if.slave     bus,
   input  logic [511:0]       reg_file_i,
   input  logic               wb_valid_i,
   input  logic [3:0]         wb_sel_i,
   input  logic [31:0]        wb_data_i,
   output logic [STALL_W-1:0] stall_cnt_o
);

   typedef struct packed {
      logic [31:0] op_a;
      logic [31:0] op_b;
      logic [3:0]  rd;
      logic [3:0]  op;
   } entry_t;

   localparam logic [1:0] FULL = 2'(DEPTH);

   entry_t               mem_q [DEPTH];
   logic                 wr_ptr_q, wr_ptr_d;
   logic                 rd_ptr_q, rd_ptr_d;
   logic [1:0]           count_q, count_d;
   logic [STALL_W-1:0]   stall_q, stall_d;

   logic                 push, pop;
   entry_t               new_entry;

   // handshake flags: in_ready is forced low while reset is asserted
   assign bus.in_ready  = (count_q < FULL) && !rst;
   assign bus.out_valid = (count_q != 2'd0);
   assign push          = bus.in_valid && bus.in_ready;
   assign pop           = bus.out_valid && bus.out_ready;

   // head entry drives the ALU-facing outputs
   assign bus.op_a   = mem_q[rd_ptr_q].op_a;
   assign bus.op_b   = mem_q[rd_ptr_q].op_b;
   assign bus.out_rd = mem_q[rd_ptr_q].rd;
   assign bus.out_op = mem_q[rd_ptr_q].op;
   assign stall_cnt_o = stall_q;

   // operand selection (and optional write-back forwarding) for the entry being pushed
   always_comb begin
      // NOTE: every signal assigned here gets a default first so no latch is inferred.
      new_entry      = '0;
      new_entry.op_a = reg_file_i[32*bus.rs_a +: 32];
      new_entry.op_b = reg_file_i[32*bus.rs_b +: 32];
      new_entry.rd   = bus.rd;
      new_entry.op   = bus.op;
`ifdef OPFETCH_BYPASS_EN
      if (wb_valid_i && (wb_sel_i == bus.rs_a)) new_entry.op_a = wb_data_i;
      if (wb_valid_i && (wb_sel_i == bus.rs_b)) new_entry.op_b = wb_data_i;
`endif
   end

`ifndef OPFETCH_BYPASS_EN
   // write-back inputs are intentionally ignored without forwarding
   logic unused_wb;
   assign unused_wb = ^{wb_valid_i, wb_sel_i, wb_data_i};
`endif

   // next-state for pointers, occupancy and the saturating stall counter
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      stall_d  = stall_q;
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
      if (bus.out_valid && !bus.out_ready && (stall_q != '1))
         stall_d = stall_q + 1'b1;
   end

   // control state registers
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge value of the others.
      if (rst) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
         stall_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         stall_q  <= stall_d;
      end
   end

   // buffer storage: operands frozen at capture
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: the entries are reset because the head entry is visible on the
      // outputs and must read as zero straight out of reset.
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (push) begin
         mem_q[wr_ptr_q] <= new_entry;
      end
   end

endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed, table-driven check of operand_fetch plus
// hand-written sequences for streaming, forwarding, stall saturation and
// mid-stream reset. A second instance with STALL_W=4 follows the same stimulus.
module tb_operand_fetch;

   logic         clk = 1'b0;
   logic         rst;
   logic [511:0] reg_file;
   logic         wb_valid;
   logic [3:0]   wb_sel;
   logic [31:0]  wb_data;
   logic [15:0]  stall_cnt;
   logic [3:0]   stall_cnt4;

   int checks = 0;
   int errors = 0;

   operand_fetch_if bus ();
   operand_fetch_if bus4 ();

   assign bus4.in_valid  = bus.in_valid;
   assign bus4.rs_a      = bus.rs_a;
   assign bus4.rs_b      = bus.rs_b;
   assign bus4.rd        = bus.rd;
   assign bus4.op        = bus.op;
   assign bus4.out_ready = bus.out_ready;

   operand_fetch #(.DEPTH(2), .STALL_W(16)) dut (
      .clk(clk), .rst(rst), .bus(bus), .reg_file_i(reg_file),
      .wb_valid_i(wb_valid), .wb_sel_i(wb_sel), .wb_data_i(wb_data),
      .stall_cnt_o(stall_cnt)
   );

   operand_fetch #(.DEPTH(2), .STALL_W(4)) dut4 (
      .clk(clk), .rst(rst), .bus(bus4), .reg_file_i(reg_file),
      .wb_valid_i(wb_valid), .wb_sel_i(wb_sel), .wb_data_i(wb_data),
      .stall_cnt_o(stall_cnt4)
   );

   always #5 clk = ~clk;

`ifdef OPFETCH_BYPASS_EN
   localparam logic [31:0] EXP_BYP = 32'hDEAD_BEEF;
`else
   localparam logic [31:0] EXP_BYP = 32'h0000_0001;
`endif

   // register bank contents
   function automatic logic [31:0] rv(input int n);
      case (n)
         3:       return 32'h0000_00AA;
         4:       return 32'h0000_0001;
         5:       return 32'h1234_5678;
         default: return 32'hC0DE_0000 | 32'(n);
      endcase
   endfunction

   typedef struct {
      logic        iv;
      logic [3:0]  ra, rb, rd, op;
      logic        ordy;
      logic        e_ov, e_ir;
      logic [31:0] e_a, e_b;
      logic [3:0]  e_rd, e_op;
      logic [15:0] e_st;
   } vec_t;

   function automatic vec_t mk(input logic iv, input logic [3:0] ra, rb, rd, op,
                               input logic ordy, input logic e_ov, e_ir,
                               input logic [31:0] e_a, e_b,
                               input logic [3:0] e_rd, e_op, input logic [15:0] e_st);
      vec_t v;
      v.iv = iv; v.ra = ra; v.rb = rb; v.rd = rd; v.op = op; v.ordy = ordy;
      v.e_ov = e_ov; v.e_ir = e_ir; v.e_a = e_a; v.e_b = e_b;
      v.e_rd = e_rd; v.e_op = e_op; v.e_st = e_st;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic iv, input logic [3:0] ra, rb, rd, op, input logic ordy);
      bus.in_valid  = iv;
      bus.rs_a      = ra;
      bus.rs_b      = rb;
      bus.rd        = rd;
      bus.op        = op;
      bus.out_ready = ordy;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   vec_t vecs [9];

   initial begin
      // single transfer, then back-pressure with a third push held off
      vecs[0] = mk(1, 3, 5, 7, 2, 0, 1, 1, 32'h0000_00AA, 32'h1234_5678, 7, 2, 0);
      vecs[1] = mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
      vecs[2] = mk(1, 1, 2, 1, 1, 0, 1, 1, 32'hC0DE_0001, 32'hC0DE_0002, 1, 1, 0);
      vecs[3] = mk(1, 6, 7, 2, 3, 0, 1, 0, 32'hC0DE_0001, 32'hC0DE_0002, 1, 1, 1);
      vecs[4] = mk(1, 8, 9, 3, 4, 0, 1, 0, 32'hC0DE_0001, 32'hC0DE_0002, 1, 1, 2);
      vecs[5] = mk(1, 8, 9, 3, 4, 0, 1, 0, 32'hC0DE_0001, 32'hC0DE_0002, 1, 1, 3);
      vecs[6] = mk(1, 8, 9, 3, 4, 1, 1, 1, 32'hC0DE_0006, 32'hC0DE_0007, 2, 3, 3);
      vecs[7] = mk(1, 8, 9, 3, 4, 1, 1, 1, 32'hC0DE_0008, 32'hC0DE_0009, 3, 4, 3);
      vecs[8] = mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 3);

      for (int n = 0; n < 16; n++) reg_file[32*n +: 32] = rv(n);
      wb_valid = 1'b0; wb_sel = 4'd0; wb_data = 32'd0;
      drive(0, 0, 0, 0, 0, 0);
      rst = 1'b1;

      // reset state
      tick(); tick();
      check("rst_out_valid", 32'(bus.out_valid), 0);
      check("rst_in_ready",  32'(bus.in_ready), 0);
      check("rst_op_a",      bus.op_a, 0);
      check("rst_stall",     32'(stall_cnt), 0);
      rst = 1'b0;
      #1;
      check("rel_in_ready",  32'(bus.in_ready), 1);
      check("rel_out_valid", 32'(bus.out_valid), 0);

      // table-driven vectors
      for (int i = 0; i < 9; i++) begin
         drive(vecs[i].iv, vecs[i].ra, vecs[i].rb, vecs[i].rd, vecs[i].op, vecs[i].ordy);
         tick();
         check($sformatf("v%0d_out_valid", i), 32'(bus.out_valid), 32'(vecs[i].e_ov));
         check($sformatf("v%0d_in_ready", i),  32'(bus.in_ready),  32'(vecs[i].e_ir));
         check($sformatf("v%0d_stall", i),     32'(stall_cnt),     32'(vecs[i].e_st));
         if (vecs[i].e_ov) begin
            check($sformatf("v%0d_op_a", i),   bus.op_a,           vecs[i].e_a);
            check($sformatf("v%0d_op_b", i),   bus.op_b,           vecs[i].e_b);
            check($sformatf("v%0d_out_rd", i), 32'(bus.out_rd),    32'(vecs[i].e_rd));
            check($sformatf("v%0d_out_op", i), 32'(bus.out_op),    32'(vecs[i].e_op));
         end
      end
      check("w4_stall_after_bp", 32'(stall_cnt4), 3);

      // streaming: one transfer per cycle, buffer never fills
      for (int k = 0; k < 8; k++) begin
         drive(1, 4'(k), 4'(15 - k), 4'(k), 4'(7 - k), 1);
         tick();
         check($sformatf("s%0d_out_valid", k), 32'(bus.out_valid), 1);
         check($sformatf("s%0d_in_ready", k),  32'(bus.in_ready), 1);
         check($sformatf("s%0d_op_a", k),      bus.op_a, rv(k));
         check($sformatf("s%0d_op_b", k),      bus.op_b, rv(15 - k));
         check($sformatf("s%0d_out_rd", k),    32'(bus.out_rd), 32'(k));
      end
      drive(0, 0, 0, 0, 0, 1);
      tick();
      check("s_drain_out_valid", 32'(bus.out_valid), 0);
      check("s_stall", 32'(stall_cnt), 3);

      // forwarding on both operands from the same write-back
      wb_valid = 1'b1; wb_sel = 4'd4; wb_data = 32'hDEAD_BEEF;
      drive(1, 4, 4, 9, 4'hA, 0);
      tick();
      check("byp_op_a", bus.op_a, EXP_BYP);
      check("byp_op_b", bus.op_b, EXP_BYP);
      check("byp_out_rd", 32'(bus.out_rd), 9);
      wb_valid = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      // later bank change must not alter the captured entry
      reg_file[32*4 +: 32] = 32'h5555_5555;

      // hold the entry for 20 stalled cycles
      for (int c = 1; c <= 20; c++) begin
         tick();
         if (c == 11) check("w4_stall_c11", 32'(stall_cnt4), 14);
      end
      check("frozen_op_a", bus.op_a, EXP_BYP);
      check("w16_stall_c20", 32'(stall_cnt), 23);
      check("w4_stall_sat", 32'(stall_cnt4), 15);

      // fill to two entries, then reset mid-stream
      drive(1, 5, 3, 1, 1, 0);
      tick();
      check("full_in_ready", 32'(bus.in_ready), 0);
      check("full_stall", 32'(stall_cnt), 24);
      drive(0, 0, 0, 0, 0, 0);
      #3;
      rst = 1'b1;
      #1;
      check("mid_rst_out_valid", 32'(bus.out_valid), 0);
      check("mid_rst_in_ready",  32'(bus.in_ready), 0);
      check("mid_rst_stall",     32'(stall_cnt), 0);
      check("mid_rst_stall4",    32'(stall_cnt4), 0);
      check("mid_rst_op_a",      bus.op_a, 0);
      tick();
      rst = 1'b0;
      #1;
      check("post_rst_in_ready",  32'(bus.in_ready), 1);
      check("post_rst_out_valid", 32'(bus.out_valid), 0);
      drive(1, 5, 3, 2, 6, 0);
      tick();
      check("post_rst_push_ov",   32'(bus.out_valid), 1);
      check("post_rst_push_op_a", bus.op_a, 32'h1234_5678);
      check("post_rst_push_op_b", bus.op_b, 32'h0000_00AA);
      check("post_rst_push_op",   32'(bus.out_op), 6);
      drive(0, 0, 0, 0, 0, 1);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
